ysyx_22041412_div_ctrl: RTL and testbench
=========================================

// Module: ysyx_22041412_div_ctrl
// PURPOSE
//  EXU-side sequencer for the multi-cycle divider. Accepts RV64M DIV/DIVU/REM/REMU[W] ops and resolves
//  RISC-V special cases locally. Issues all other ops to ysyx_22041412_div and holds its operand/mode
//  inputs stable, then sign-extends W results. Presents the final result on a valid/ready writeback port.
// PARAMETERS
//  XLEN         64  datapath width
//  TIMEOUT_CYC  16  max cycles in WAIT/DRAIN before err_timeout
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous active-high reset
//  ex_valid       in   1     op offered by EXU
//  ex_ready       out  1     block can accept op
//  ex_op          in   2     0 DIV, 1 DIVU, 2 REM, 3 REMU
//  ex_word        in   1     W variant (32-bit, result sign-extended)
//  ex_src1        in   XLEN  dividend
//  ex_src2        in   XLEN  divisor
//  ex_rd          in   5     destination tag, returned unchanged
//  flush          in   1     kill in-flight op
//  div_valid      out  1     one-cycle issue pulse to divider
//  div_dividend   out  XLEN  held from ISSUE until result captured
//  div_divisor    out  XLEN  held likewise
//  divw           out  1     held likewise
//  div_signed     out  1     held likewise
//  div_mode       out  1     0 quotient / 1 remainder; held likewise
//  div_out_valid  in   1     divider result pulse
//  div_result     in   XLEN  divider result, sampled only when div_out_valid=1
//  wb_valid       out  1     result available
//  wb_ready       in   1     writeback accepts
//  wb_result      out  XLEN  final result
//  wb_rd          out  5     tag
//  err_timeout    out  1     sticky; set on watchdog expiry
// BEHAVIOUR
//  - Reset: state IDLE; ex_ready=1; div_valid=0; wb_valid=0; err_timeout=0; all data outputs 0.
//  - FSM IDLE->(ISSUE|DONE); ISSUE->WAIT; WAIT->DONE; DONE->IDLE; DRAIN->IDLE.
//  - ex_ready=1 only in IDLE; accept on ex_valid&ex_ready; latch op, word, srcs, rd.
//  - Special cases (operand width 32 if word else XLEN), resolved at accept, next state DONE:
//    - divisor==0: quotient=all-ones, remainder=dividend.
//    - signed op with dividend==MIN and divisor==-1: quotient=dividend, remainder=0.
//    - Op->DONE latency 1 cycle.
//  - Normal ops:
//    - ISSUE lasts exactly 1 cycle with div_valid=1; divw=ex_word; div_signed=~op[0]; div_mode=op[1].
//    - WAIT: div_valid=0; capture div_result on div_out_valid, then DONE.
//    - Nominal ex_valid->wb_valid latency: 4 cycles.
//  - W results: wb_result = sext(div_result[31:0]) (divider zero-extends); XLEN results pass through.
//  - DONE: wb_valid=1, result/rd stable until wb_ready; on wb_valid&wb_ready -> IDLE.
//    New op accepted no earlier than the following cycle.
//  - flush:
//    - In ISSUE/WAIT -> DRAIN: wait for div_out_valid, discard result, -> IDLE.
//      div_* outputs stay held while draining.
//    - flush in DONE -> IDLE; wb_valid drops next cycle.
//    - flush in IDLE/DRAIN: no effect.
//    - flush coincident with div_out_valid in WAIT -> IDLE, no wb.
//  - Watchdog:
//    - Counter clears on entering WAIT/DRAIN and counts each cycle there.
//    - When it reaches TIMEOUT_CYC: err_timeout<=1.
//    - WAIT -> DONE with result 0; DRAIN -> IDLE.
//  - rst mid-operation returns to IDLE immediately; the divider shares rst.
// CONFIGURATION
//  - DIV_CTRL_LASTRES_EN defined: keep one entry {word, op, src1, src2, result}, valid cleared by rst.
//    - Updated on every DONE entry from the divider.
//    - Exact-match accepted op -> DONE in 1 cycle, no div_valid.
//    - Entry is not updated on flush/timeout.
//  - DIV_CTRL_LASTRES_EN undefined: no entry; every normal op issues to divider.
// STRUCTURE
//  - Shared package ysyx_22041412_pkg: div op encodings, FSM state encoding, XLEN.
//  - Special-case detector is one natural sub-module: ysyx_22041412_div_special (combinational).
//  - The FSM, watchdog and optional entry stay in this module.
// TESTING
//  - DIVW src1=-7 src2=2 -> issue pulse 1 cycle; wb_result=0xFFFFFFFF_FFFFFFFD (-3).
//  - REMU src1=100 src2=0 -> no div_valid; wb_valid 1 cycle after accept; wb_result=100.
//  - DIV src1=0x8000000000000000 src2=-1 -> wb_result=0x8000000000000000.
//    REMW same pattern in 32 bits -> 0.
//  - DIVU 20/3 with wb_ready low 3 cycles -> wb_valid, wb_result=6, rd held until ready.
//  - flush one cycle after ISSUE -> DRAIN, no wb_valid, ex_ready returns after divider pulse.
//  - div_out_valid never returned -> err_timeout=1 after 16 WAIT cycles; wb_result=0.
//    With DIV_CTRL_LASTRES_EN, repeated op -> no div_valid.

Source files
------------

// File: rtl/ysyx_22041412_pkg.sv
// Shared definitions for the divider sequencer: datapath width, op encodings,
// FSM state encoding, the last-result entry payload and small op helpers.
package ysyx_22041412_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned WORD_W = 32;

  // RV64M divide op encoding as presented by the EXU
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  // Last divider result, keyed by the full operation
  typedef struct packed {
    logic            word;
    logic [1:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] result;
  } div_lastres_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-WORD_W){x[WORD_W-1]}}, x[WORD_W-1:0]};
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ysyx_22041412_div_special.sv
// Combinational detector for the RISC-V divide special cases (divide by zero
// and signed overflow) with the architecturally defined result.
// Ports:
//   op, word       op encoding and W flag
//   src1, src2     dividend, divisor
//   special_c      operands hit a special case
//   result_c       final (already sign-extended for W) result of that case
module ysyx_22041412_div_special
  import ysyx_22041412_pkg::*;
(
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            special_c,
  output logic [XLEN-1:0] result_c
);

  localparam logic [XLEN-1:0]   XMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [WORD_W-1:0] WMIN = {1'b1, {(WORD_W-1){1'b0}}};

  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] dividend;

  // Detect cases on the effective operand width
  always_comb begin
    special_c = 1'b0;
    result_c  = '0;
    dividend  = word ? sext_word(src1) : src1;
    div_zero  = word ? (src2[WORD_W-1:0] == '0) : (src2 == '0);
    ovf       = op_is_signed(op) &&
                (word ? (src1[WORD_W-1:0] == WMIN && src2[WORD_W-1:0] == '1)
                      : (src1 == XMIN && src2 == '1));
    if (div_zero) begin
      special_c = 1'b1;
      result_c  = op_is_rem(op) ? dividend : '1;
    end else if (ovf) begin
      special_c = 1'b1;
      result_c  = op_is_rem(op) ? '0 : dividend;
    end
  end

endmodule

// File: rtl/ysyx_22041412_div_ctrl.sv
// EXU-side sequencer for the multi-cycle divider. Resolves special cases at
// accept, otherwise issues to the divider, holds its inputs, waits for the
// result (with a watchdog), sign-extends W results and offers the result on a
// valid/ready writeback port. Optional macro DIV_CTRL_LASTRES_EN adds a
// one-entry last-result store that short-circuits exact repeats.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   ex_valid/ex_ready/ex_op/ex_word/
//   ex_src1/ex_src2/ex_rd              op offer from EXU
//   flush                              kill in-flight op
//   div_valid, div_dividend, div_divisor,
//   divw, div_signed, div_mode         divider issue (held until captured)
//   div_out_valid, div_result          divider result
//   wb_valid/wb_ready/wb_result/wb_rd  writeback
//   err_timeout                        sticky watchdog error
module ysyx_22041412_div_ctrl
  import ysyx_22041412_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_op,
  input  logic            ex_word,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            div_valid,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            divw,
  output logic            div_signed,
  output logic            div_mode,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd,
  output logic            err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  div_state_e      state_q, state_d;
  logic [WD_W-1:0] wd_cnt_q;
  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic            hit_c;
  logic [XLEN-1:0] hit_res_c;
  logic            accept_c;
  logic            capture_c;
  logic            timeout_c;
  logic            wd_hit_c;
  logic [XLEN-1:0] res_c;

  ysyx_22041412_div_special u_special (
    .op        (ex_op),
    .word      (ex_word),
    .src1      (ex_src1),
    .src2      (ex_src2),
    .special_c (special_c),
    .result_c  (special_res_c)
  );

  // Divider zero-extends W results
  assign res_c = divw ? sext_word(div_result) : div_result;

`ifdef DIV_CTRL_LASTRES_EN
  div_lastres_t lr_q;
  logic         lr_vld_q;

  assign hit_c = lr_vld_q && (lr_q.word == ex_word) && (lr_q.op == ex_op) &&
                 (lr_q.src1 == ex_src1) && (lr_q.src2 == ex_src2);
  assign hit_res_c = lr_q.result;

  // Entry refreshed only by genuine divider results
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_vld_q <= 1'b0;
      lr_q     <= '0;
    end else if (capture_c) begin
      lr_vld_q <= 1'b1;
      lr_q     <= '{word: divw, op: {div_mode, ~div_signed},
                    src1: div_dividend, src2: div_divisor, result: res_c};
    end
  end
`else
  assign hit_c     = 1'b0;
  assign hit_res_c = '0;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    wd_hit_c  = (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          accept_c = 1'b1;
          state_d  = (special_c || hit_c) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (div_out_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            capture_c = 1'b1;
            state_d   = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || wb_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_out_valid) begin
          state_d = ST_IDLE;
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wd_cnt_q     <= '0;
      ex_ready     <= 1'b1;
      div_valid    <= 1'b0;
      wb_valid     <= 1'b0;
      err_timeout  <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      divw         <= 1'b0;
      div_signed   <= 1'b0;
      div_mode     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
    end else begin
      state_q   <= state_d;
      ex_ready  <= (state_d == ST_IDLE);
      div_valid <= (state_d == ST_ISSUE);
      wb_valid  <= (state_d == ST_DONE);

      // Watchdog restarts on every entry into WAIT or DRAIN
      if ((state_d != state_q) && (state_d == ST_WAIT || state_d == ST_DRAIN))
        wd_cnt_q <= '0;
      else if (state_q == ST_WAIT || state_q == ST_DRAIN)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);

      if (accept_c) begin
        wb_rd <= ex_rd;
        if (special_c) begin
          wb_result <= special_res_c;
        end else if (hit_c) begin
          wb_result <= hit_res_c;
        end else begin
          div_dividend <= ex_src1;
          div_divisor  <= ex_src2;
          divw         <= ex_word;
          div_signed   <= op_is_signed(ex_op);
          div_mode     <= op_is_rem(ex_op);
        end
      end

      if (capture_c) wb_result <= res_c;

      if (timeout_c) begin
        err_timeout <= 1'b1;
        if (state_q == ST_WAIT) wb_result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_div_ctrl.sv
module tb_ysyx_22041412_div_ctrl;
  import ysyx_22041412_pkg::*;

  logic            clk;
  logic            rst;
  logic            ex_valid;
  logic            ex_ready;
  logic [1:0]      ex_op;
  logic            ex_word;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_src2;
  logic [4:0]      ex_rd;
  logic            flush;
  logic            div_valid;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            divw;
  logic            div_signed;
  logic            div_mode;
  logic            div_out_valid;
  logic [XLEN-1:0] div_result;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_result;
  logic [4:0]      wb_rd;
  logic            err_timeout;

  int checks = 0;
  int errors = 0;

  ysyx_22041412_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_op        (ex_op),
    .ex_word      (ex_word),
    .ex_src1      (ex_src1),
    .ex_src2      (ex_src2),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .div_valid    (div_valid),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .divw         (divw),
    .div_signed   (div_signed),
    .div_mode     (div_mode),
    .div_out_valid(div_out_valid),
    .div_result   (div_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op, input logic word,
                       input logic [63:0] s1, input logic [63:0] s2, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_word  = word;
    ex_src1  = s1;
    ex_src2  = s2;
    ex_rd    = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = 2'd0; ex_word = 1'b0;
    ex_src1 = '0; ex_src2 = '0; ex_rd = '0; flush = 1'b0;
    div_out_valid = 1'b0; div_result = '0; wb_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_wb_result", wb_result, 64'd0);
    chk("rst_div_dividend", div_dividend, 64'd0);

    // DIVW -7 / 2: divider returns zero-extended -3
    offer(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5);
    chk("divw_issue", 64'(div_valid), 64'd1);
    chk("divw_ex_ready", 64'(ex_ready), 64'd0);
    chk("divw_ctl", 64'({divw, div_signed, div_mode}), 64'b110);
    chk("divw_dividend", div_dividend, 64'hFFFF_FFFF_FFFF_FFF9);
    tick();
    chk("divw_pulse_once", 64'(div_valid), 64'd0);
    chk("divw_held", div_divisor, 64'd2);
    div_out_valid = 1'b1; div_result = 64'h0000_0000_FFFF_FFFD;
    tick();
    div_out_valid = 1'b0;
    chk("divw_wb_valid", 64'(wb_valid), 64'd1);
    chk("divw_wb_result", wb_result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("divw_wb_rd", 64'(wb_rd), 64'd5);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("divw_wb_drop", 64'(wb_valid), 64'd0);
    chk("divw_idle", 64'(ex_ready), 64'd1);

    // REMU 100 / 0: resolved locally
    offer(2'd3, 1'b0, 64'd100, 64'd0, 5'd7);
    chk("remu0_no_issue", 64'(div_valid), 64'd0);
    chk("remu0_wb_valid", 64'(wb_valid), 64'd1);
    chk("remu0_result", wb_result, 64'd100);
    chk("remu0_rd", 64'(wb_rd), 64'd7);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // DIV MIN / -1 overflow
    offer(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    chk("divovf_no_issue", 64'(div_valid), 64'd0);
    chk("divovf_result", wb_result, 64'h8000_0000_0000_0000);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // REMW MIN32 / -1 overflow (upper bits ignored)
    offer(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd2);
    chk("remwovf_wb_valid", 64'(wb_valid), 64'd1);
    chk("remwovf_result", wb_result, 64'd0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // DIVU 20 / 3 with writeback back-pressure
    offer(2'd1, 1'b0, 64'd20, 64'd3, 5'd9);
    chk("divu_issue", 64'(div_valid), 64'd1);
    chk("divu_ctl", 64'({divw, div_signed, div_mode}), 64'b000);
    tick();
    tick();
    div_out_valid = 1'b1; div_result = 64'd6;
    tick();
    div_out_valid = 1'b0;
    ex_valid = 1'b1; ex_op = 2'd2; ex_src1 = 64'd9; ex_src2 = 64'd0; ex_rd = 5'd30;
    for (int i = 0; i < 3; i++) begin
      chk("divu_bp_valid", 64'(wb_valid), 64'd1);
      chk("divu_bp_result", wb_result, 64'd6);
      chk("divu_bp_rd", 64'(wb_rd), 64'd9);
      chk("divu_bp_no_accept", 64'(ex_ready), 64'd0);
      tick();
    end
    ex_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("divu_wb_drop", 64'(wb_valid), 64'd0);
    chk("divu_idle", 64'(ex_ready), 64'd1);

    // Flush one cycle after ISSUE drains the divider
    offer(2'd0, 1'b0, 64'd50, 64'd5, 5'd3);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy", 64'(ex_ready), 64'd0);
    chk("drain_no_wb", 64'(wb_valid), 64'd0);
    chk("drain_held", div_dividend, 64'd50);
    tick();
    chk("drain_still_busy", 64'(ex_ready), 64'd0);
    div_out_valid = 1'b1; div_result = 64'd10;
    tick();
    div_out_valid = 1'b0;
    chk("drain_done_ready", 64'(ex_ready), 64'd1);
    chk("drain_done_no_wb", 64'(wb_valid), 64'd0);

    // Flush while holding a result in DONE
    offer(2'd2, 1'b0, 64'd7, 64'd0, 5'd4);
    chk("flushdone_wb", 64'(wb_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushdone_drop", 64'(wb_valid), 64'd0);
    chk("flushdone_ready", 64'(ex_ready), 64'd1);

    // Watchdog: divider never answers
    offer(2'd0, 1'b0, 64'd1000, 64'd10, 5'd11);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("wd_not_yet", 64'(err_timeout), 64'd0);
    chk("wd_not_yet_wb", 64'(wb_valid), 64'd0);
    tick();
    chk("wd_err", 64'(err_timeout), 64'd1);
    chk("wd_wb_valid", 64'(wb_valid), 64'd1);
    chk("wd_result", wb_result, 64'd0);
    chk("wd_rd", 64'(wb_rd), 64'd11);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wd_sticky", 64'(err_timeout), 64'd1);

    // Repeat of the last divider-computed op (DIVU 20 / 3)
    offer(2'd1, 1'b0, 64'd20, 64'd3, 5'd12);
`ifdef DIV_CTRL_LASTRES_EN
    chk("rep_no_issue", 64'(div_valid), 64'd0);
    chk("rep_wb_valid", 64'(wb_valid), 64'd1);
    chk("rep_result", wb_result, 64'd6);
`else
    chk("rep_issue", 64'(div_valid), 64'd1);
    tick();
    div_out_valid = 1'b1; div_result = 64'd6;
    tick();
    div_out_valid = 1'b0;
    chk("rep_result", wb_result, 64'd6);
`endif
    chk("rep_rd", 64'(wb_rd), 64'd12);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // Reset in the middle of an operation
    offer(2'd0, 1'b0, 64'd81, 64'd9, 5'd13);
    chk("midrst_issue", 64'(div_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 64'(ex_ready), 64'd1);
    chk("midrst_div_valid", 64'(div_valid), 64'd0);
    chk("midrst_err", 64'(err_timeout), 64'd0);
    chk("midrst_dividend", div_dividend, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
